// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated edge-count frequency meter for an asynchronous input
//
// Purpose:
//   Counts rising edges of the asynchronous input sig_in over back-to-back gate
//   windows of GATE_CYCLES clk cycles. Each completed window reports its edge
//   count (saturated to CNT_W bits) with a one-cycle freq_valid strobe.
//
// Ports:
//   clk         in   1      system clock, all logic on posedge
//   rst         in   1      asynchronous active-high reset
//   en          in   1      measurement enable, synchronous to clk
//   sig_in      in   1      signal under measurement, asynchronous to clk
//   freq_count  out  CNT_W  edges counted in the last completed window
//   freq_valid  out  1      one-cycle strobe, result outputs just updated
//   overflow    out  1      last window saturated the edge counter
//   no_signal   out  1      last window counted zero edges
//   busy        out  1      meter is settling or gating

module freq_meter #(
  parameter int GATE_CYCLES = 12000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_valid,
  output logic             overflow,
  output logic             no_signal,
  output logic             busy
);

  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2
  } state_t;

  state_t             state_q,      state_d;
  logic               s1_q,         s1_d;
  logic               s2_q,         s2_d;
  logic               s3_q,         s3_d;
  logic [GATE_W-1:0]  gate_cnt_q,   gate_cnt_d;
  logic [CNT_W-1:0]   edge_cnt_q,   edge_cnt_d;
  logic               settle_cnt_q, settle_cnt_d;
  logic               ovf_pend_q,   ovf_pend_d;
  logic [CNT_W-1:0]   freq_count_q, freq_count_d;
  logic               freq_valid_q, freq_valid_d;
  logic               overflow_q,   overflow_d;
  logic               no_signal_q,  no_signal_d;

  logic               rise;
  logic               edge_at_max;
  logic               window_end;

  // s1 is the metastability catcher; the edge is detected between s2 and s3
  // so only settled values feed the counter.
  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  assign rise        = s2_q & ~s3_q;
  assign edge_at_max = (edge_cnt_q == CNT_MAX);
  assign window_end  = (gate_cnt_q == GATE_LAST);

  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    settle_cnt_d = settle_cnt_q;
    ovf_pend_d   = ovf_pend_q;
    freq_count_d = freq_count_q;
    overflow_d   = overflow_q;
    no_signal_d  = no_signal_q;
    freq_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        gate_cnt_d   = '0;
        edge_cnt_d   = '0;
        settle_cnt_d = 1'b0;
        ovf_pend_d   = 1'b0;
        if (en) begin
          state_d = ST_SETTLE;
        end
      end

      // Two cycles with rise ignored, so a stale edge held in the
      // synchronizer from before enable never lands in the first window.
      ST_SETTLE: begin
        if (!en) begin
          state_d      = ST_IDLE;
          settle_cnt_d = 1'b0;
        end else if (settle_cnt_q) begin
          state_d      = ST_GATE;
          settle_cnt_d = 1'b0;
          gate_cnt_d   = '0;
          edge_cnt_d   = '0;
          ovf_pend_d   = 1'b0;
        end else begin
          settle_cnt_d = 1'b1;
        end
      end

      ST_GATE: begin
        if (!en) begin
          // Partial window is dropped; reported results stay untouched.
          state_d    = ST_IDLE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_pend_d = 1'b0;
        end else if (window_end) begin
          // A rise in the closing cycle is folded into this window's result,
          // and the counters restart so the next window begins immediately.
          freq_count_d = (rise && edge_at_max) ? CNT_MAX
                                               : edge_cnt_q + CNT_W'(rise);
          overflow_d   = ovf_pend_q | (rise & edge_at_max);
          no_signal_d  = (edge_cnt_q == '0) & ~rise;
          freq_valid_d = 1'b1;
          gate_cnt_d   = '0;
          edge_cnt_d   = '0;
          ovf_pend_d   = 1'b0;
        end else begin
          gate_cnt_d = gate_cnt_q + GATE_W'(1);
          if (rise) begin
            if (edge_at_max) begin
              ovf_pend_d = 1'b1;
            end else begin
              edge_cnt_d = edge_cnt_q + CNT_W'(1);
            end
          end
        end
      end

      default: begin
        state_d      = ST_IDLE;
        gate_cnt_d   = '0;
        edge_cnt_d   = '0;
        settle_cnt_d = 1'b0;
        ovf_pend_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      settle_cnt_q <= 1'b0;
      ovf_pend_q   <= 1'b0;
      freq_count_q <= '0;
      freq_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      no_signal_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      ovf_pend_q   <= ovf_pend_d;
      freq_count_q <= freq_count_d;
      freq_valid_q <= freq_valid_d;
      overflow_q   <= overflow_d;
      no_signal_q  <= no_signal_d;
    end
  end

  assign freq_count = freq_count_q;
  assign freq_valid = freq_valid_q;
  assign overflow   = overflow_q;
  assign no_signal  = no_signal_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - scoreboard bench for freq_meter with edge-time reference model

module tb_freq_meter;

  localparam int G = 100;

  logic       clk = 1'b0;
  logic       rst, en, sig_in;
  logic [7:0] f8;
  logic [3:0] f4;
  logic       v8, v4, o8, o4, n8, n4, b8, b4;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq_count(f8), .freq_valid(v8), .overflow(o8), .no_signal(n8), .busy(b8)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq_count(f4), .freq_valid(v4), .overflow(o4), .no_signal(n4), .busy(b4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors  = 0;
  int   miscomps = 0;

  // rise_at[p]: number of sig_in rising edges that the meter sees at posedge p
  int   rise_at[0:19999];
  int   gen_period = 0;
  int   gen_ref    = 0;
  logic en_next    = 1'b0;
  logic rst_next   = 1'b1;
  logic model_active = 1'b0;
  int   win_end    = 0;
  int   last_cnt   = 0;

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscomps++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
    end
  endtask

  // One clock of stimulus plus the reference model, applied on the negedge.
  task automatic step();
    logic s;
    int   sum;
    @(negedge clk);
    rst = rst_next;
    en  = en_next;
    if (rst || !en) begin
      model_active = 1'b0;
    end else if (!model_active) begin
      // en sampled next posedge: 1 cycle to leave IDLE, 2 settling, then G gating
      model_active = 1'b1;
      win_end      = cyc + 3 + G;
    end
    if (gen_period == 0 || cyc < gen_ref) s = 1'b0;
    else s = ((cyc - gen_ref) % gen_period) < (gen_period / 2);
    if (s && !sig_in) rise_at[cyc + 3]++;
    sig_in = s;
    if (model_active && cyc == win_end - 1) begin
      sum = 0;
      for (int i = win_end - G + 1; i <= win_end; i++) sum += rise_at[i];
      exp_q.push_back('{cyc: win_end, cnt: sum});
      last_cnt = sum;
      win_end += G;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_gen(input int period, input int ref_cyc);
    gen_period = period;
    gen_ref    = ref_cyc;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (v8 || v4) begin
        chk("valid_agree", int'(v8), int'(v4));
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("count8", int'(f8), sat(e.cnt, 8));
          chk("ovf8", int'(o8), int'(e.cnt > 255));
          chk("nosig8", int'(n8), int'(e.cnt == 0));
          chk("count4", int'(f4), sat(e.cnt, 4));
          chk("ovf4", int'(o4), int'(e.cnt > 15));
          chk("nosig4", int'(n4), int'(e.cnt == 0));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk("missing_pulse_at", cyc, e.cyc);
      end
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < 20000; i++) rise_at[i] = 0;
    rst = 1'b1; en = 1'b0; sig_in = 1'b0;
    run(3);

    chk("rst_count8", int'(f8), 0);
    chk("rst_valid8", int'(v8), 0);
    chk("rst_ovf8", int'(o8), 0);
    chk("rst_nosig8", int'(n8), 0);
    chk("rst_busy8", int'(b8), 0);
    chk("rst_count4", int'(f4), 0);
    chk("rst_busy4", int'(b4), 0);
    rst_next = 1'b0;
    run(2);

    // period 10, 5 high / 5 low
    set_gen(10, cyc + 7);
    en_next = 1'b1;
    run(350);
    chk("busy_running", int'(b8), 1);

    // held low
    set_gen(0, 0);
    run(230);

    // 25 edges per window saturate the 4-bit meter, then back to period 10
    set_gen(4, cyc + 1);
    run(220);
    set_gen(10, cyc + 1);
    run(220);

    // a rise lands on the last cycle of a window; the pattern continues
    set_gen(10, win_end + G - 3 - 50);
    run(6 * G);

    for (int k = 0; k < 6; k++) begin
      set_gen($urandom_range(30, 4), cyc + $urandom_range(12, 1));
      run($urandom_range(220, 90));
    end

    // drop en halfway through a window after a good period-10 window
    set_gen(10, cyc + 1);
    run(250);
    guard = 0;
    while (win_end - cyc != 50 && guard < 300) begin
      step();
      guard++;
    end
    chk("reach_mid_window", int'(guard < 300), 1);
    en_next = 1'b0;
    run(2);
    chk("busy_after_drop", int'(b8), 0);
    chk("held_count8", int'(f8), sat(last_cnt, 8));
    chk("held_count4", int'(f4), sat(last_cnt, 4));
    run(150);
    chk("held_count8_late", int'(f8), sat(last_cnt, 8));
    en_next = 1'b1;
    run(250);

    // asynchronous reset mid-window, released with en still high
    guard = 0;
    while (win_end - cyc != 40 && guard < 300) begin
      step();
      guard++;
    end
    #2;
    rst          = 1'b1;
    rst_next     = 1'b1;
    model_active = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_count8", int'(f8), 0);
    chk("arst_count4", int'(f4), 0);
    chk("arst_busy8", int'(b8), 0);
    chk("arst_ovf4", int'(o4), 0);
    chk("arst_nosig8", int'(n8), 0);
    run(4);
    rst_next = 1'b0;
    run(330);

    en_next = 1'b0;
    run(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomps);
    $finish;
  end

endmodule
